// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared constants and ALU operation codes for the OTTER execute stage
package otter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'b0000,
        ALU_SUB     = 4'b1000,
        ALU_SLL     = 4'b0001,
        ALU_SLT     = 4'b0010,
        ALU_SLTU    = 4'b0011,
        ALU_XOR     = 4'b0100,
        ALU_SRL     = 4'b0101,
        ALU_SRA     = 4'b1101,
        ALU_OR      = 4'b0110,
        ALU_AND     = 4'b0111,
        ALU_LUI_CPY = 4'b1001
    } alu_fun_t;

endpackage

// File: rtl/otter_exec_unit_if.sv
// rtl/otter_exec_unit_if.sv - execute-stage operand and result bundle
interface otter_exec_unit_if;
    import otter_pkg::*;

    logic            EN;
    logic [3:0]      ALU_FUN;
    logic [XLEN-1:0] SRC_A;
    logic [XLEN-1:0] SRC_B;
    logic [XLEN-1:0] RS1;
    logic [XLEN-1:0] RS2;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] I_TYPE;
    logic [XLEN-1:0] J_TYPE;
    logic [XLEN-1:0] B_TYPE;
    logic [XLEN-1:0] RESULT;
    logic [XLEN-1:0] JAL;
    logic [XLEN-1:0] JALR;
    logic [XLEN-1:0] BRANCH;
    logic            BR_EQ;
    logic            BR_LT;
    logic            BR_LTU;

    modport master (
        output EN, ALU_FUN, SRC_A, SRC_B, RS1, RS2, PC, I_TYPE, J_TYPE, B_TYPE,
        input  RESULT, JAL, JALR, BRANCH, BR_EQ, BR_LT, BR_LTU
    );

    modport slave (
        input  EN, ALU_FUN, SRC_A, SRC_B, RS1, RS2, PC, I_TYPE, J_TYPE, B_TYPE,
        output RESULT, JAL, JALR, BRANCH, BR_EQ, BR_LT, BR_LTU
    );

endinterface

// File: rtl/otter_alu_core.sv
// rtl/otter_alu_core.sv - combinational RV32I ALU
module otter_alu_core
    import otter_pkg::*;
(
    input  logic [3:0]      alu_fun_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o
);

    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    // Decode the operation; unused codes produce zero rather than X
    always_comb begin
        result_o = '0;
        case (alu_fun_i)
            ALU_ADD:     result_o = a_i + b_i;
            ALU_SUB:     result_o = a_i - b_i;
            ALU_SLL:     result_o = a_i << shamt;
            ALU_SLT:     result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:    result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            ALU_XOR:     result_o = a_i ^ b_i;
            ALU_SRL:     result_o = a_i >> shamt;
            ALU_SRA:     result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:      result_o = a_i | b_i;
            ALU_AND:     result_o = a_i & b_i;
            ALU_LUI_CPY: result_o = a_i;
            default:     result_o = '0;
        endcase
    end

endmodule

// File: rtl/otter_exec_unit.sv
// rtl/otter_exec_unit.sv - registered ALU, branch target and branch condition stage
module otter_exec_unit
    import otter_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic             CLK,
    input  logic             RST,
    otter_exec_unit_if.slave bus
);

    logic [XLEN_P-1:0] result_d, result_q;
    logic [XLEN_P-1:0] jal_d,    jal_q;
    logic [XLEN_P-1:0] jalr_d,   jalr_q;
    logic [XLEN_P-1:0] branch_d, branch_q;
    logic              eq_d,  eq_q;
    logic              lt_d,  lt_q;
    logic              ltu_d, ltu_q;

    otter_alu_core u_alu (
        .alu_fun_i (bus.ALU_FUN),
        .a_i       (bus.SRC_A),
        .b_i       (bus.SRC_B),
        .result_o  (result_d)
    );

    // Branch targets and condition flags, evaluated every cycle alongside the ALU
    always_comb begin
        jal_d    = bus.PC + bus.J_TYPE;
        jalr_d   = (bus.RS1 + bus.I_TYPE) & ~{{(XLEN_P-1){1'b0}}, 1'b1};
        branch_d = bus.PC + bus.B_TYPE;
        eq_d     = (bus.RS1 == bus.RS2);
        lt_d     = ($signed(bus.RS1) < $signed(bus.RS2));
        ltu_d    = (bus.RS1 < bus.RS2);
    end

    // Output stage: reset wins over enable, EN low holds everything
    always_ff @(posedge CLK) begin
        if (RST) begin
            result_q <= '0;
            jal_q    <= '0;
            jalr_q   <= '0;
            branch_q <= '0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            ltu_q    <= 1'b0;
        end else if (bus.EN) begin
            result_q <= result_d;
            jal_q    <= jal_d;
            jalr_q   <= jalr_d;
            branch_q <= branch_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            ltu_q    <= ltu_d;
        end
    end

    assign bus.RESULT = result_q;
    assign bus.JAL    = jal_q;
    assign bus.JALR   = jalr_q;
    assign bus.BRANCH = branch_q;
    assign bus.BR_EQ  = eq_q;
    assign bus.BR_LT  = lt_q;
    assign bus.BR_LTU = ltu_q;

endmodule

// File: tb/tb_otter_exec_unit.sv
// tb/tb_otter_exec_unit.sv - scoreboard bench for otter_exec_unit
module tb_otter_exec_unit;

    logic CLK;
    logic RST;
    otter_exec_unit_if bus ();

    otter_exec_unit dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] result;
        logic [31:0] jal;
        logic [31:0] jalr;
        logic [31:0] branch;
        logic        eq;
        logic        lt;
        logic        ltu;
    } exp_t;

    exp_t exp_q[$];
    exp_t model;
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned ua, ub, p2;
        longint          sa, sb;
        int              s;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        s  = b % 32;
        p2 = 64'd1 << s;
        case (f)
            4'd0:  return 32'((ua + ub) % 64'h1_0000_0000);
            4'd8:  return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
            4'd1:  return 32'((ua * p2) % 64'h1_0000_0000);
            4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd3:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return 32'(ua / p2);
            4'd13: return (sa < 0) ? 32'(64'h1_0000_0000 - ((-sa + longint'(p2) - 1) / longint'(p2)))
                                   : 32'(ua / p2);
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd9:  return a;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic rst, input logic en, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] it,
                         input logic [31:0] jt, input logic [31:0] bt);
        longint sr1, sr2;
        RST = rst; bus.EN = en; bus.ALU_FUN = f; bus.SRC_A = a; bus.SRC_B = b;
        bus.RS1 = rs1; bus.RS2 = rs2; bus.PC = pc; bus.I_TYPE = it;
        bus.J_TYPE = jt; bus.B_TYPE = bt;
        sr1 = $signed(rs1); sr2 = $signed(rs2);
        if (rst) begin
            model = '{32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
        end else if (en) begin
            model.result = ref_alu(f, a, b);
            model.jal    = 32'((longint'(pc) + longint'(jt)) % 64'h1_0000_0000);
            model.branch = 32'((longint'(pc) + longint'(bt)) % 64'h1_0000_0000);
            model.jalr   = 32'((((longint'(rs1) + longint'(it)) % 64'h1_0000_0000) / 2) * 2);
            model.eq     = (rs1 == rs2);
            model.lt     = (sr1 < sr2);
            model.ltu    = (longint'(rs1) < longint'(rs2));
        end
        exp_q.push_back(model);
        @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%08h required=%08h", name, act, req);
    endtask

    // Monitor: one registered result per rising edge, checked on the following falling edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("RESULT", bus.RESULT, e.result);
                chk("JAL",    bus.JAL,    e.jal);
                chk("JALR",   bus.JALR,   e.jalr);
                chk("BRANCH", bus.BRANCH, e.branch);
                chk("BR_EQ",  {31'd0, bus.BR_EQ},  {31'd0, e.eq});
                chk("BR_LT",  {31'd0, bus.BR_LT},  {31'd0, e.lt});
                chk("BR_LTU", {31'd0, bus.BR_LTU}, {31'd0, e.ltu});
            end
        end
    end

    initial begin
        int wait_cyc;
        model = '{32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
        // reset with random inputs
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom);
        // directed ALU cases
        drive(0, 1, 4'b0000, 32'hFFFFFFFF, 32'd2, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 4'b1000, 32'd0, 32'd1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 4'b1101, 32'h80000000, 32'h24, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 4'b0101, 32'h80000000, 32'h24, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 4'b0001, 32'd1, 32'd31, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 4'b0010, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 4'b0011, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 4'b1001, 32'h12345000, 32'h5, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 4'b1111, 32'hDEADBEEF, 32'h1, 0, 0, 0, 0, 0, 0);
        // branch address generator
        drive(0, 1, 4'b0000, 0, 0, 32'h201, 32'h0, 32'h100, 32'd4, 32'hFFFFFFF0, 32'd8);
        // branch condition generator
        drive(0, 1, 4'b0000, 0, 0, 32'd5, 32'd5, 0, 0, 0, 0);
        drive(0, 1, 4'b0000, 0, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 0);
        drive(0, 1, 4'b0000, 0, 0, 32'd1, 32'hFFFFFFFF, 0, 0, 0, 0);
        // stall holds, then reset during stall
        drive(0, 1, 4'b0000, 32'd3, 32'd4, 32'h77, 32'h9, 32'h400, 32'h11, 32'h20, 32'h30);
        for (int i = 0; i < 3; i++)
            drive(0, 0, 4'($urandom), $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom);
        drive(1, 0, 4'($urandom), $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom);
        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] r1, r2;
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 4'($urandom),
                  $urandom, ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 63))),
                  r1, r2, $urandom, $urandom, $urandom, $urandom);
        end
        RST = 1'b0; bus.EN = 1'b0;
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge CLK);
            wait_cyc++;
        end
        @(negedge CLK);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
